ax_decision_ctrl: RTL and testbench
===================================

Name: ax_decision_ctrl

Overview:
- Per-cycle precise/approximate decision controller for approximate-computing lanes (e.g. load or AX-branch lanes).
- Holds the software-configured approximation level and a 32-bit Galois LFSR.
- Each requesting lane gets a registered approximate/precise decision with probability level/2^AX_LEVEL_WIDTH.
- Caps consecutive approximations per lane; sits between the CSR write path and the approximating pipelines.

Parameters:
AX_LEVEL_WIDTH, 5, width of approximation level and of each per-lane random slice
LFSR_WIDTH, 32, LFSR width; must satisfy REQ_NUM*AX_LEVEL_WIDTH <= LFSR_WIDTH
LFSR_SEED, 32'h1010, reset seed and substitute for an illegal all-zero seed
REQ_NUM, 2, number of requesting lanes
MAX_CONSEC, 4, maximum back-to-back approximate decisions per lane before one forced precise decision

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cfgLevelWe  in  1  write strobe for level
cfgLevel  in  AX_LEVEL_WIDTH  new approximation level
cfgSeedWe  in  1  write strobe for seed
cfgSeed  in  LFSR_WIDTH  new LFSR seed
flush  in  1  pipeline flush; clears consecutive counters and drops in-flight decisions
reqValid  in  REQ_NUM  lane i requests a decision this cycle
decValid  out  REQ_NUM  decision for lane i valid (one cycle after request)
decApprox  out  REQ_NUM  1 = approximate, 0 = precise
curLevel  out  AX_LEVEL_WIDTH  current level
busy  out  1  high while in RESEED state
statApproxCount  out  32  approximate-decision count (feature-dependent)

Behaviour:
- Clock and reset: one clock domain, clk. Synchronous active-low reset on rst_n.
- Reset values: lfsr=LFSR_SEED, level=0, state=DISABLED, all consecutive counters=0, decValid=0, decApprox=0, busy=0, statApproxCount=0.
- FSM states:
  - DISABLED (level==0).
  - ACTIVE (level!=0).
  - RESEED (one cycle).
- FSM transitions:
  - Level write: takes effect on the next cycle. Writing 0 goes to DISABLED; writing non-zero from DISABLED goes to ACTIVE.
  - cfgSeedWe from any state: loads the seed, or LFSR_SEED if cfgSeed==0, and enters RESEED for exactly one cycle. It then returns to ACTIVE or DISABLED per the current level.
  - cfgSeedWe and cfgLevelWe in the same cycle: both apply.
- Decision (1-cycle latency):
  - For lane i with reqValid[i] in cycle N: decValid[i]=1 in N+1.
  - Random slice r_i = lfsr[i*AX_LEVEL_WIDTH +: AX_LEVEL_WIDTH], taken from the lfsr value in cycle N.
  - decApprox[i]=1 iff state==ACTIVE && r_i < level && consec[i] < MAX_CONSEC.
  - In DISABLED or RESEED, every request is answered precise. decValid still asserts, so requests are never dropped except on flush.
- LFSR:
  - Galois, right shift, polynomial x^32+x^22+x^2+x+1 (tap mask 32'h80200003).
  - Next = (lfsr>>1) ^ (lfsr[0] ? mask : 0).
  - Advances once per cycle when state==ACTIVE and |reqValid. Holds otherwise.
  - A seed write overrides the advance.
- Consecutive counter per lane, width clog2(MAX_CONSEC+1):
  - Approximate decision: increment.
  - Precise decision: clear to 0. A forced precise decision (counter at MAX_CONSEC) also clears.
  - Unrequested lanes hold their counter.
- Flush:
  - Clears all consec counters and forces decValid=0 in the next cycle, even for requests issued in the flush cycle.
  - Does not affect lfsr, level or state.
- Level is compared unsigned. level = 2^AX_LEVEL_WIDTH-1 gives maximum probability (31/32), still subject to the MAX_CONSEC cap.

Optional Feature:
AX_DECISION_STATS_EN:
- Defined: statApproxCount is a 32-bit saturating counter.
  - Increments by popcount of approximate decisions issued each cycle; it counts the registered decApprox&decValid.
  - Reset to 0 by rst_n or by cfgSeedWe.
  - Saturates at 32'hFFFFFFFF.
- Undefined: statApproxCount is tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset, level 0, reqValid=2'b11 for 10 cycles -> decValid=2'b11 each following cycle, decApprox=0, lfsr stays 32'h1010.
- Level 17, seed 32'h1010, reqValid=2'b11 -> slices r0=16, r1=0; next cycle decApprox=2'b11; lfsr becomes 32'h00000808.
- Level 16, seed 32'h1010, one request -> decApprox=2'b10 (lane0 precise, lane1 approximate).
- Level 31, MAX_CONSEC=4, lane1 (r1 stays <31) requesting every cycle -> pattern approx x4, precise, approx x4...; flush mid-run -> no decValid next cycle, counter restarts at 0.
- cfgSeedWe with cfgSeed=0 while ACTIVE -> busy=1 one cycle, requests in that cycle answered precise, lfsr=32'h1010 afterwards.
- With AX_DECISION_STATS_EN: 5 cycles of 2 approx decisions each -> statApproxCount=10; a seed write clears it to 0.

Source files
------------

// File: rtl/ax_decision_ctrl.sv
// Precise/approximate decision controller: level register, 32-bit Galois LFSR,
// per-lane consecutive-approximation cap. Optional statistics via AX_DECISION_STATS_EN.
module ax_decision_ctrl #(
  parameter int                    AX_LEVEL_WIDTH = 5,
  parameter int                    LFSR_WIDTH     = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED      = LFSR_WIDTH'(32'h1010),
  parameter int                    REQ_NUM        = 2,
  parameter int                    MAX_CONSEC     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfgLevelWe,
  input  logic [AX_LEVEL_WIDTH-1:0] cfgLevel,
  input  logic                      cfgSeedWe,
  input  logic [LFSR_WIDTH-1:0]     cfgSeed,
  input  logic                      flush,
  input  logic [REQ_NUM-1:0]        reqValid,
  output logic [REQ_NUM-1:0]        decValid,
  output logic [REQ_NUM-1:0]        decApprox,
  output logic [AX_LEVEL_WIDTH-1:0] curLevel,
  output logic                      busy,
  output logic [31:0]               statApproxCount
);

  localparam int                    CONSEC_W   = $clog2(MAX_CONSEC + 1);
  localparam logic [CONSEC_W-1:0]   CONSEC_MAX = CONSEC_W'(MAX_CONSEC);
  localparam logic [LFSR_WIDTH-1:0] TAP_MASK   = LFSR_WIDTH'(32'h80200003);

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_ACTIVE,
    ST_RESEED
  } state_t;

  state_t                      state, state_next;
  logic [AX_LEVEL_WIDTH-1:0]   level, level_next;
  logic [LFSR_WIDTH-1:0]       lfsr, lfsr_next;
  logic [CONSEC_W-1:0]         consec      [REQ_NUM];
  logic [CONSEC_W-1:0]         consec_next [REQ_NUM];
  logic [REQ_NUM-1:0]          approx_hit;

  // A level written during RESEED must decide where the controller lands afterwards.
  always_comb begin
    state_next = state;
    level_next = cfgLevelWe ? cfgLevel : level;
    if (cfgSeedWe)
      state_next = ST_RESEED;
    else if (state == ST_RESEED || cfgLevelWe)
      state_next = (level_next != '0) ? ST_ACTIVE : ST_DISABLED;
  end

  always_comb begin
    lfsr_next = lfsr;
    if (cfgSeedWe)
      lfsr_next = (cfgSeed == '0) ? LFSR_SEED : cfgSeed;
    else if (state == ST_ACTIVE && |reqValid)
      lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAP_MASK : '0);
  end

  // Each lane draws its own slice of the current LFSR value.
  always_comb begin
    approx_hit = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      approx_hit[i] = (state == ST_ACTIVE)
                   && (lfsr[i*AX_LEVEL_WIDTH +: AX_LEVEL_WIDTH] < level)
                   && (consec[i] < CONSEC_MAX);
    end
  end

  always_comb begin
    for (int i = 0; i < REQ_NUM; i++) begin
      consec_next[i] = consec[i];
      if (flush)
        consec_next[i] = '0;
      else if (reqValid[i])
        consec_next[i] = approx_hit[i] ? consec[i] + CONSEC_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_DISABLED;
      level     <= '0;
      lfsr      <= LFSR_SEED;
      decValid  <= '0;
      decApprox <= '0;
      for (int i = 0; i < REQ_NUM; i++) consec[i] <= '0;
    end else begin
      state     <= state_next;
      level     <= level_next;
      lfsr      <= lfsr_next;
      decValid  <= flush ? '0 : reqValid;
      decApprox <= flush ? '0 : (reqValid & approx_hit);
      for (int i = 0; i < REQ_NUM; i++) consec[i] <= consec_next[i];
    end
  end

  assign curLevel = level;
  assign busy     = (state == ST_RESEED);

`ifdef AX_DECISION_STATS_EN
  localparam int POP_W = $clog2(REQ_NUM + 1);

  logic [POP_W-1:0] approx_pop;
  logic [32:0]      stat_sum;
  logic [31:0]      stat_count;

  always_comb begin
    approx_pop = '0;
    for (int i = 0; i < REQ_NUM; i++)
      if (decApprox[i] && decValid[i]) approx_pop = approx_pop + POP_W'(1);
    stat_sum = {1'b0, stat_count} + 33'(approx_pop);
  end

  // Counts issued decisions; a carry out of bit 31 pins the counter at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || cfgSeedWe)
      stat_count <= '0;
    else if (stat_sum[32])
      stat_count <= '1;
    else
      stat_count <= stat_sum[31:0];
  end

  assign statApproxCount = stat_count;
`else
  assign statApproxCount = '0;
`endif

endmodule

// File: tb/tb_ax_decision_ctrl.sv
// Directed bench for ax_decision_ctrl; expected LFSR slices are hand-derived from
// seed 32'h1010 (1010, 808, 404, 202, 101, 80200083, ...).
module tb_ax_decision_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfgLevelWe;
  logic [4:0]  cfgLevel;
  logic        cfgSeedWe;
  logic [31:0] cfgSeed;
  logic        flush;
  logic [1:0]  reqValid;
  logic [1:0]  decValid;
  logic [1:0]  decApprox;
  logic [4:0]  curLevel;
  logic        busy;
  logic [31:0] statApproxCount;

  int check_count = 0;
  int fail_count  = 0;

`ifdef AX_DECISION_STATS_EN
  localparam logic [31:0] STAT_EXP = 32'd10;
`else
  localparam logic [31:0] STAT_EXP = 32'd0;
`endif

  ax_decision_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfgLevelWe      (cfgLevelWe),
    .cfgLevel        (cfgLevel),
    .cfgSeedWe       (cfgSeedWe),
    .cfgSeed         (cfgSeed),
    .flush           (flush),
    .reqValid        (reqValid),
    .decValid        (decValid),
    .decApprox       (decApprox),
    .curLevel        (curLevel),
    .busy            (busy),
    .statApproxCount (statApproxCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs; outputs are sampled 1ns after the edge.
  task automatic applyStimulus(input logic lvl_we, input logic [4:0] lvl,
                               input logic seed_we, input logic [31:0] seed,
                               input logic fl, input logic [1:0] req);
    cfgLevelWe = lvl_we;
    cfgLevel   = lvl;
    cfgSeedWe  = seed_we;
    cfgSeed    = seed;
    flush      = fl;
    reqValid   = req;
    @(posedge clk);
    #1;
  endtask

  logic consec_pat_a [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic consec_pat_b [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n = 1'b0;
    cfgLevelWe = 1'b0; cfgLevel = '0; cfgSeedWe = 1'b0; cfgSeed = '0;
    flush = 1'b0; reqValid = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_decValid", 32'(decValid), 32'd0);
    checkOutput("rst_decApprox", 32'(decApprox), 32'd0);
    checkOutput("rst_curLevel", 32'(curLevel), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_stat", statApproxCount, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b11);
      checkOutput("dis_decValid", 32'(decValid), 32'h3);
      checkOutput("dis_decApprox", 32'(decApprox), 32'h0);
    end

    // Level 16 with lfsr still at 1010: r0=16 precise, r1=0 approximate.
    applyStimulus(1'b1, 5'd16, 1'b0, 32'h0, 1'b0, 2'b00);
    checkOutput("lvl16_curLevel", 32'(curLevel), 32'd16);
    checkOutput("lvl16_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b11);
    checkOutput("lvl16_dec0", 32'(decApprox), 32'h2);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b11);
    checkOutput("lvl16_dec1", 32'(decApprox), 32'h3);

    // Seed and level written together; the request in that cycle uses old state (lfsr 404).
    applyStimulus(1'b1, 5'd17, 1'b1, 32'h1010, 1'b0, 2'b11);
    checkOutput("both_busy", 32'(busy), 32'd1);
    checkOutput("both_curLevel", 32'(curLevel), 32'd17);
    checkOutput("both_decApprox", 32'(decApprox), 32'h3);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b11);
    checkOutput("reseed_busy", 32'(busy), 32'd0);
    checkOutput("reseed_decValid", 32'(decValid), 32'h3);
    checkOutput("reseed_decApprox", 32'(decApprox), 32'h0);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b11);
    checkOutput("lvl17_decApprox", 32'(decApprox), 32'h3);

    // Consecutive cap on lane1 at level 31 with a flush in the middle.
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 2'b00);
    checkOutput("pre_flush_decValid", 32'(decValid), 32'h0);
    applyStimulus(1'b1, 5'd31, 1'b1, 32'h1010, 1'b0, 2'b00);
    checkOutput("cap_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b00);
    checkOutput("cap_busy_clear", 32'(busy), 32'd0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b10);
      checkOutput("cap_a_decValid", 32'(decValid), 32'h2);
      checkOutput("cap_a_decApprox", 32'(decApprox), {30'd0, consec_pat_a[i], 1'b0});
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 2'b10);
    checkOutput("flush_decValid", 32'(decValid), 32'h0);
    checkOutput("flush_decApprox", 32'(decApprox), 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b10);
      checkOutput("cap_b_decValid", 32'(decValid), 32'h2);
      checkOutput("cap_b_decApprox", 32'(decApprox), {30'd0, consec_pat_b[i], 1'b0});
    end

    // Zero seed is replaced by 1010; level 16 then exposes r0=16.
    applyStimulus(1'b0, 5'd0, 1'b1, 32'h0, 1'b0, 2'b00);
    checkOutput("seed0_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b11);
    checkOutput("seed0_busy_clear", 32'(busy), 32'd0);
    checkOutput("seed0_decValid", 32'(decValid), 32'h3);
    checkOutput("seed0_decApprox", 32'(decApprox), 32'h0);
    applyStimulus(1'b1, 5'd16, 1'b0, 32'h0, 1'b0, 2'b00);
    checkOutput("seed0_curLevel", 32'(curLevel), 32'd16);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b11);
    checkOutput("seed0_lfsr_dec", 32'(decApprox), 32'h2);

    applyStimulus(1'b1, 5'd0, 1'b0, 32'h0, 1'b0, 2'b00);
    checkOutput("lvl0_curLevel", 32'(curLevel), 32'd0);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b11);
    checkOutput("lvl0_decValid", 32'(decValid), 32'h3);
    checkOutput("lvl0_decApprox", 32'(decApprox), 32'h0);

    // Five cycles of two approximations each, split by a flush to dodge the cap.
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 2'b00);
    applyStimulus(1'b1, 5'd31, 1'b1, 32'h1010, 1'b0, 2'b00);
    checkOutput("stat_cleared", statApproxCount, 32'd0);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b11);
      checkOutput("stat_decApprox", 32'(decApprox), 32'h3);
    end
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b1, 2'b00);
    checkOutput("stat_flush_decValid", 32'(decValid), 32'h0);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b11);
    checkOutput("stat_last_decApprox", 32'(decApprox), 32'h3);
    applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 2'b00);
    checkOutput("stat_count", statApproxCount, STAT_EXP);
    applyStimulus(1'b0, 5'd0, 1'b1, 32'h1234, 1'b0, 2'b00);
    checkOutput("stat_seed_clear", statApproxCount, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
